ram_port_b_reader: RTL and testbench
====================================

Name: ram_port_b_reader

Overview:
- Sequential burst reader for port B of the shared 512x8 dual-port RAM. Port A is the writer side; this block is the other end.
- On a start command it issues consecutive port-B read addresses and absorbs the RAM's registered read latency.
- Delivers the read bytes as a valid/ready stream with a last marker.
- Sits between the RAM and downstream consumers, for example a UART TX or display logic.

Parameters:
- ADDR_W, 9, RAM address width; the address space is 2^ADDR_W words.
- DATA_W, 8, RAM word width.
- RAM_LAT, 1, port-B read latency in cycles, from addrb to doutb valid.
- LEN_W, 10, width of the length field; allows up to 2^ADDR_W+ words.

Ports:
- clkb  in  1  single clock, rising edge; same clock as RAM port B.
- rstb_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first address of the burst; captured on start.
- length  in  LEN_W  number of words to read; captured on start.
- busy  out  1  high from the cycle after an accepted start until the final beat is handed off.
- done  out  1  one-cycle pulse after the final beat handshake, or after a zero-length start.
- addrb  out  ADDR_W  RAM port-B address.
- web  out  1  RAM port-B write enable; constant 0.
- dinb  out  DATA_W  RAM port-B write data; constant 0.
- doutb  in  DATA_W  RAM port-B read data.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final beat of the burst.

Behaviour:
- Reset (rstb_n=0, asynchronous):
  - State returns to IDLE and the FIFO and in-flight pipeline are flushed.
  - busy=0, done=0, m_valid=0, m_last=0, m_data=0, addrb=0.
  - Release is synchronous to clkb.
- States:
  - IDLE: start=1 with length≠0 goes to RUN. start=1 with length=0 pulses done on the next cycle, stays in IDLE, produces no beats.
  - RUN: issues reads. Goes to DRAIN once `length` reads have been issued.
  - DRAIN: waits until the FIFO is empty and the final beat has handshaken, then pulses done and goes to IDLE.
- Read issue (RUN):
  - One read per cycle when fifo_count + inflight < FIFO_DEPTH, where FIFO_DEPTH = RAM_LAT+2.
  - Otherwise addrb holds and no read is issued.
  - Address after each issued read: addrb <= addrb+1, modulo 2^ADDR_W, so the address wraps from 511 to 0.
- Data return:
  - An RAM_LAT-deep valid shift register tracks each issued read.
  - doutb is written into the output FIFO exactly RAM_LAT cycles after its addrb cycle.
  - No beat is ever dropped or duplicated.
- Stream rules:
  - Once m_valid=1, m_data and m_last hold stable until m_valid && m_ready.
  - m_last=1 only on beat number `length`.
  - Beats are delivered in address order.
- Latency:
  - start sampled in cycle 0.
  - addrb=base_addr in cycle 1.
  - doutb valid in cycle 1+RAM_LAT.
  - First m_valid=1 in cycle 2+RAM_LAT.
  - With m_ready held at 1, throughput is 1 beat per cycle.
- start while busy: ignored; parameters are not re-captured.
- length greater than 2^ADDR_W: the read wraps and re-reads the same addresses. This is legal.
- Ownership: the write-side logic must not write the range being read while busy. The block does not check this.

Optional Feature:
- Macro: RD_CHECKSUM_EN.
- When defined:
  - Output port csum (out, DATA_W) is present.
  - csum is the XOR of every m_data accepted (valid && ready) in the current burst.
  - It is cleared on an accepted start and holds its final value from the done pulse until the next accepted start.
  - Reset value is 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Setup for all scenarios: RAM preloaded so that mem[i] = i[7:0].
- Basic burst: base=5, length=4, m_ready=1 → beats 05,06,07,08; m_last only on 08; first m_valid in cycle 3; done one cycle after the 08 handshake.
- Wrap: base=510, length=4 → addrb sequence 510,511,0,1; beats FE,FF,00,01.
- Backpressure: base=0, length=16, m_ready toggling 1,0,1,0 → 16 beats 00..0F in order, no duplicates; data stable while stalled; fifo_count never exceeds 3.
- Zero length and ignored start: length=0 → done pulses in cycle 1, m_valid never rises. A second start during a busy burst → ignored, original beats unaffected.
- Reset mid-burst: rstb_n=0 after 3 beats of a 10-word burst → all outputs reach reset values immediately. A following base=20, length=2 burst → beats 14,15 with no stale data.
- Checksum (RD_CHECKSUM_EN defined): base=1, length=3 → csum = 01^02^03 = 00 at done. base=1, length=4 → csum = 04.

Source files
------------

// File: rtl/ram_port_b_reader_if.sv
// Port-B reader bundle: command/status, RAM port-B pins and the output byte stream.
// RD_CHECKSUM_EN adds the csum signal to the bundle.
interface ram_port_b_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] addrb;
  logic              web;
  logic [DATA_W-1:0] dinb;
  logic [DATA_W-1:0] doutb;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
`ifdef RD_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  modport master (
    input  start, base_addr, length, doutb, m_ready,
    output busy, done, addrb, web, dinb, m_data, m_valid, m_last
`ifdef RD_CHECKSUM_EN
    , output csum
`endif
  );

  modport slave (
    output start, base_addr, length, doutb, m_ready,
    input  busy, done, addrb, web, dinb, m_data, m_valid, m_last
`ifdef RD_CHECKSUM_EN
    , input csum
`endif
  );
endinterface

// File: rtl/ram_port_b_reader.sv
// Burst reader for RAM port B: first beat 2+RAM_LAT cycles after start, 1 beat/cycle; reads stall
// when FIFO plus in-flight reads would exceed RAM_LAT+2, so m_ready backpressure never drops data. RD_CHECKSUM_EN adds csum.
module ram_port_b_reader #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1,
  parameter int LEN_W   = 10
) (
  input  logic clkb,
  input  logic rstb_n,
  ram_port_b_reader_if.master rd_if
);
  localparam int DEPTH = RAM_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + RAM_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_issue_left;
  logic [LEN_W-1:0]   r_beat_left;
  logic [RAM_LAT-1:0] r_sr;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_done;
  logic [CNT_W-1:0]   w_inflight;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_start_ok;
  logic               w_final_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RAM_LAT; i++) w_inflight = w_inflight + CNT_W'(r_sr[i]);
  end

  // Reserve a FIFO slot for every read still in the RAM pipeline before issuing another.
  assign w_issue     = (r_state == S_RUN) && ((r_count + w_inflight) < CNT_W'(DEPTH));
  assign w_push      = r_sr[RAM_LAT-1];
  assign w_pop       = rd_if.m_valid && rd_if.m_ready;
  assign w_start_ok  = (r_state == S_IDLE) && rd_if.start;
  assign w_final_pop = (r_state == S_DRAIN) && w_pop && (r_beat_left == LEN_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (rd_if.start && (rd_if.length != '0)) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && (r_issue_left == LEN_W'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_final_pop) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_beat_left  <= '0;
      r_sr         <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_start_ok && (rd_if.length == '0)) || w_final_pop;
      if (w_start_ok) begin
        r_addr       <= rd_if.base_addr;
        r_issue_left <= rd_if.length;
        r_beat_left  <= rd_if.length;
      end else begin
        if (w_issue) begin
          r_addr       <= r_addr + 1'b1;
          r_issue_left <= r_issue_left - 1'b1;
        end
        if (w_pop) r_beat_left <= r_beat_left - 1'b1;
      end
      r_sr[0] <= w_issue;
      for (int i = 1; i < RAM_LAT; i++) r_sr[i] <= r_sr[i-1];
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count flush it.
  always_ff @(posedge clkb) begin
    if (w_push) r_mem[r_wptr] <= rd_if.doutb;
  end

  assign rd_if.busy    = (r_state != S_IDLE);
  assign rd_if.done    = r_done;
  assign rd_if.addrb   = r_addr;
  assign rd_if.web     = 1'b0;
  assign rd_if.dinb    = '0;
  assign rd_if.m_valid = (r_count != '0);
  assign rd_if.m_data  = rd_if.m_valid ? r_mem[r_rptr] : '0;
  assign rd_if.m_last  = rd_if.m_valid && (r_beat_left == LEN_W'(1));

`ifdef RD_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n)         r_csum <= '0;
    else if (w_start_ok) r_csum <= '0;
    else if (w_pop)      r_csum <= r_csum ^ rd_if.m_data;
  end

  assign rd_if.csum = r_csum;
`endif
endmodule

// File: tb/tb_ram_port_b_reader.sv
// Bench for ram_port_b_reader: a bench-side RAM with mem[i]=i, a queue-based burst model checked
// every cycle, directed scenarios pinned with literal values, then randomized bursts and backpressure.
module tb_ram_port_b_reader;
  localparam int ADDR_W = 9, DATA_W = 8, RAM_LAT = 1, LEN_W = 10;

  logic clkb   = 1'b0;
  logic rstb_n = 1'b0;
  always #5 clkb = ~clkb;

  ram_port_b_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  ram_port_b_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .LEN_W(LEN_W)) dut (
    .clkb   (clkb),
    .rstb_n (rstb_n),
    .rd_if  (bus.master)
  );

  logic [7:0] mem [512];
  always @(posedge clkb) bus.doutb <= mem[bus.addrb];

  typedef struct {logic [7:0] d; logic l;} beat_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  beat_t      exp_q[$];
  bit         m_busy, exp_done, fin, stall_prev;
  logic [7:0] prev_d;
  logic       prev_l;
  logic [7:0] m_csum;
  logic [7:0] got_q[$];
  int         last_at[$];
  int         addr_q[$];
  int         start_cyc, first_lat, done_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare DUT against the model for the current cycle, then advance the model by what the coming edge does.
  task automatic check();
    bit    busy_now;
    beat_t b;
    if (!rstb_n) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_last", bus.m_last, 0);
      chk("rst_data", bus.m_data, 0);
      chk("rst_addrb", bus.addrb, 0);
`ifdef RD_CHECKSUM_EN
      chk("rst_csum", bus.csum, 0);
`endif
      exp_q.delete();
      m_busy = 0; exp_done = 0; stall_prev = 0; m_csum = 8'h00;
      cyc++;
      return;
    end
    busy_now = m_busy;
    chk("busy", bus.busy, m_busy);
    chk("done", bus.done, exp_done);
    if (exp_done) fin = 1;
    if (bus.done && done_lat < 0) done_lat = cyc - start_cyc;
    exp_done = 0;
    chk("web_dinb", {bus.web, bus.dinb}, 0);
`ifdef RD_CHECKSUM_EN
    chk("csum", bus.csum, m_csum);
`endif
    if (busy_now && (addr_q.size() == 0 || addr_q[$] != int'(bus.addrb))) addr_q.push_back(int'(bus.addrb));
    if (stall_prev) begin
      chk("hold_valid", bus.m_valid, 1);
      chk("hold_data", bus.m_data, prev_d);
      chk("hold_last", bus.m_last, prev_l);
    end
    if (bus.m_valid) begin
      if (first_lat < 0) first_lat = cyc - start_cyc;
      if (exp_q.size() == 0) chk("spurious_valid", bus.m_valid, 0);
      else begin
        b = exp_q[0];
        chk("data", bus.m_data, b.d);
        chk("last", bus.m_last, b.l);
        if (bus.m_ready) begin
          void'(exp_q.pop_front());
          got_q.push_back(bus.m_data);
          if (bus.m_last) last_at.push_back(got_q.size());
          m_csum = m_csum ^ b.d;
          if (b.l) begin m_busy = 0; exp_done = 1; end
        end
      end
    end
    stall_prev = bus.m_valid && !bus.m_ready;
    prev_d = bus.m_data;
    prev_l = bus.m_last;
    if (bus.start && !busy_now) begin
      start_cyc = cyc; first_lat = -1; done_lat = -1; m_csum = 8'h00;
      addr_q.delete();
      if (bus.length == 0) exp_done = 1;
      else begin
        m_busy = 1;
        for (int k = 0; k < int'(bus.length); k++) begin
          b.d = mem[(int'(bus.base_addr) + k) % 512];
          b.l = (k == int'(bus.length) - 1);
          exp_q.push_back(b);
        end
      end
    end
    cyc++;
  endtask

  task automatic step(input bit s, input logic [8:0] ba, input logic [9:0] ln, input bit rdy);
    bus.start = s; bus.base_addr = ba; bus.length = ln; bus.m_ready = rdy;
    #1;
    check();
    @(negedge clkb);
  endtask

  function automatic bit rdy_of(input int mode, input int i);
    if (mode == 1) return (i % 2) == 0;
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  task automatic run_burst(input logic [8:0] ba, input logic [9:0] ln, input int mode, input int stray_at);
    fin = 0; got_q.delete(); last_at.delete();
    step(1, ba, ln, rdy_of(mode, 0));
    for (int i = 1; i < 3000 && !fin; i++) begin
      if (i == stray_at) step(1, 9'($urandom_range(0, 511)), 10'($urandom_range(1, 20)), rdy_of(mode, i));
      else               step(0, 9'd0, 10'd0, rdy_of(mode, i));
    end
    chk("burst_done", fin, 1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    bus.start = 0; bus.base_addr = '0; bus.length = '0; bus.m_ready = 0;
    m_busy = 0; exp_done = 0; stall_prev = 0; m_csum = 8'h00;
    start_cyc = 0; first_lat = -1; done_lat = -1; fin = 0;
    @(negedge clkb);
    for (int i = 0; i < 3; i++) step(0, 9'd0, 10'd0, 1'b0);
    rstb_n = 1'b1;
    step(0, 9'd0, 10'd0, 1'b1);
    step(0, 9'd0, 10'd0, 1'b1);

    // Basic burst
    run_burst(9'd5, 10'd4, 0, 0);
    chk("basic_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) chk("basic_beat", got_q[k], 32'(5 + k));
    chk("basic_last_n", last_at.size(), 1);
    if (last_at.size() > 0) chk("basic_last_pos", last_at[0], 4);
    chk("basic_first_valid_cycle", first_lat, 3);

    // Address wrap
    run_burst(9'd510, 10'd4, 0, 0);
    chk("wrap_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("wrap_b0", got_q[0], 8'hFE); chk("wrap_b1", got_q[1], 8'hFF);
      chk("wrap_b2", got_q[2], 8'h00); chk("wrap_b3", got_q[3], 8'h01);
    end
    chk("wrap_addr_n", addr_q.size() >= 4, 1);
    if (addr_q.size() >= 4) begin
      chk("wrap_a0", addr_q[0], 510); chk("wrap_a1", addr_q[1], 511);
      chk("wrap_a2", addr_q[2], 0);   chk("wrap_a3", addr_q[3], 1);
    end

    // Toggling backpressure
    run_burst(9'd0, 10'd16, 1, 0);
    chk("bp_count", got_q.size(), 16);
    for (int k = 0; k < 16 && k < got_q.size(); k++) chk("bp_beat", got_q[k], 32'(k));

    // Zero length
    run_burst(9'd7, 10'd0, 0, 0);
    chk("zero_done_cycle", done_lat, 1);
    chk("zero_beats", got_q.size(), 0);

    // Start while busy is ignored
    run_burst(9'd40, 10'd6, 0, 2);
    chk("ign_count", got_q.size(), 6);
    for (int k = 0; k < 6 && k < got_q.size(); k++) chk("ign_beat", got_q[k], 32'(40 + k));

    // Reset in the middle of a burst
    fin = 0; got_q.delete();
    step(1, 9'd0, 10'd10, 1'b1);
    for (int i = 0; i < 50 && got_q.size() < 3; i++) step(0, 9'd0, 10'd0, 1'b1);
    chk("pre_reset_beats", got_q.size(), 3);
    rstb_n = 1'b0;
    step(0, 9'd0, 10'd0, 1'b1);
    step(0, 9'd0, 10'd0, 1'b1);
    rstb_n = 1'b1;
    step(0, 9'd0, 10'd0, 1'b1);
    run_burst(9'd20, 10'd2, 0, 0);
    chk("post_reset_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("post_reset_b0", got_q[0], 8'h14);
      chk("post_reset_b1", got_q[1], 8'h15);
    end

`ifdef RD_CHECKSUM_EN
    run_burst(9'd1, 10'd3, 0, 0);
    chk("csum_len3", bus.csum, 8'h00);
    run_burst(9'd1, 10'd4, 2, 0);
    chk("csum_len4", bus.csum, 8'h04);
`endif

    // Randomized bursts, lengths, backpressure and stray starts
    for (int t = 0; t < 30; t++) begin
      int ln;
      int md;
      ln = ($urandom_range(0, 9) == 0) ? int'($urandom_range(513, 530)) : int'($urandom_range(0, 24));
      md = int'($urandom_range(0, 2));
      run_burst(9'($urandom_range(0, 511)), 10'(ln), md, (ln >= 4) ? int'($urandom_range(1, ln - 1)) : 0);
      chk("rand_count", got_q.size(), 32'(ln));
    end
    step(0, 9'd0, 10'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
